// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt controller: register indices,
// controller state encoding and the claim-valid flag position.
package gpio_irq_pkg;

    // Register indices decoded from PADDR[4:2]
    localparam logic [2:0] IRQ_PENDING = 3'd0;
    localparam logic [2:0] IRQ_ENABLE  = 3'd1;
    localparam logic [2:0] IRQ_CLAIM   = 3'd2;
    localparam logic [2:0] IRQ_OVERRUN = 3'd3;
    localparam logic [2:0] IRQ_SETPEND = 3'd4;
    localparam logic [2:0] IRQ_STATUS  = 3'd5;

    // Bit of a CLAIM read that marks the returned ID as valid
    localparam int CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, scanning upward and wrapping modulo N (N need not be a power of 2).
module rr_arbiter #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    // Requests rotated so that bit 0 corresponds to the source at ptr
    logic [N-1:0]  req_rot;
    logic [ID_W:0] cand;

    assign req_rot = N'({req, req} >> ptr);

    // Lowest rotated offset wins; the offset is mapped back to a source ID
    always_comb begin
        gnt_id    = '0;
        gnt_valid = |req;
        cand      = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                cand = {1'b0, ptr} + (ID_W + 1)'(j);
                if (cand >= (ID_W + 1)'(N)) begin
                    cand = cand - (ID_W + 1)'(N);
                end
                gnt_id = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: latches per-pin pulses into pending bits,
// masks them, arbitrates round-robin and drives one CPU interrupt line
// serviced through an APB claim/complete handshake.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    input  logic [N_SRC-1:0] irq_i,
    output logic             irq_o
);

    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] overrun_q;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  claimed_id;
    irq_state_e       state_q;
    irq_state_e       state_d;

    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;

    logic             access;
    logic             wr;
    logic             rd;
    logic [2:0]       reg_idx;
    logic [N_SRC-1:0] wdata_src;
    logic [N_SRC-1:0] w1c_pend;
    logic [N_SRC-1:0] w1c_ovr;
    logic [N_SRC-1:0] set_pend;
    logic [N_SRC-1:0] claim_clr;
    logic             claim_rd;
    logic             complete;
    logic             unused_bits;

    // Returns (id + 1) mod N_SRC
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        logic [ID_W:0] nxt;
        nxt = {1'b0, id} + (ID_W + 1)'(1);
        if (nxt >= (ID_W + 1)'(N_SRC)) begin
            nxt = '0;
        end
        return nxt[ID_W-1:0];
    endfunction

    assign access    = PSEL & PENABLE;
    assign wr        = access & PWRITE;
    assign rd        = access & ~PWRITE;
    assign reg_idx   = PADDR[4:2];
    assign wdata_src = PWDATA[N_SRC-1:0];

    // Only PADDR[4:2] and the low data bits carry meaning
    assign unused_bits = ^{PADDR, PWDATA};

    assign w1c_pend = (wr && reg_idx == IRQ_PENDING) ? wdata_src : '0;
    assign w1c_ovr  = (wr && reg_idx == IRQ_OVERRUN) ? wdata_src : '0;
    assign set_pend = (wr && reg_idx == IRQ_SETPEND) ? wdata_src : '0;

    // A claim only succeeds while the line is raised and a grant still exists
    assign claim_rd  = rd && reg_idx == IRQ_CLAIM && state_q == IRQ_ASSERT && gnt_valid;
    assign claim_clr = claim_rd ? (N_SRC'(1) << gnt_id) : '0;
    assign complete  = wr && reg_idx == IRQ_CLAIM && state_q == IRQ_SERVICE
                       && PWDATA[ID_W-1:0] == claimed_id;

    rr_arbiter #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_arb (
        .req       (pending_q & enable_q),
        .ptr       (rr_ptr),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Pending/enable/overrun registers, round-robin pointer and claimed ID
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            pending_q  <= '0;
            enable_q   <= '0;
            overrun_q  <= '0;
            rr_ptr     <= '0;
            claimed_id <= '0;
        end else begin
            // New events beat both clear sources in the same cycle
            pending_q <= (pending_q & ~w1c_pend & ~claim_clr) | irq_i | set_pend;
            overrun_q <= (overrun_q & ~w1c_ovr) | (irq_i & pending_q);
            if (wr && reg_idx == IRQ_ENABLE) begin
                enable_q <= wdata_src;
            end
            if (claim_rd) begin
                claimed_id <= gnt_id;
            end
            if (complete) begin
                rr_ptr <= wrap_inc(claimed_id);
            end
        end
    end

    // Controller state register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and interrupt line
    always_comb begin
        state_d = state_q;
        irq_o   = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (gnt_valid) state_d = IRQ_ASSERT;
            end
            IRQ_ASSERT: begin
                irq_o = PRESETn;
                if (!gnt_valid)    state_d = IRQ_IDLE;
                else if (claim_rd) state_d = IRQ_SERVICE;
            end
            IRQ_SERVICE: begin
                if (complete) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // Read mux; zero outside a read access phase
    always_comb begin
        PRDATA = '0;
        if (rd && PRESETn) begin
            case (reg_idx)
                IRQ_PENDING: PRDATA[N_SRC-1:0] = pending_q;
                IRQ_ENABLE:  PRDATA[N_SRC-1:0] = enable_q;
                IRQ_CLAIM: begin
                    if (claim_rd) begin
                        PRDATA[CLAIM_VALID_BIT] = 1'b1;
                        PRDATA[ID_W-1:0]        = gnt_id;
                    end
                end
                IRQ_OVERRUN: PRDATA[N_SRC-1:0] = overrun_q;
                IRQ_STATUS: begin
                    PRDATA[1:0]       = state_q;
                    PRDATA[8+:ID_W]   = rr_ptr;
                    PRDATA[16+:ID_W]  = claimed_id;
                end
                default: PRDATA = '0;
            endcase
        end
    end

    assign PREADY = access & PRESETn;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: an 8-source instance for the main
// scenarios and a 5-source instance for pointer wrap on a non-power-of-2 size.
module tb_gpio_irq_ctrl;

    localparam logic [31:0] A_PENDING = 32'h00;
    localparam logic [31:0] A_ENABLE  = 32'h04;
    localparam logic [31:0] A_CLAIM   = 32'h08;
    localparam logic [31:0] A_OVERRUN = 32'h0C;
    localparam logic [31:0] A_SETPEND = 32'h10;
    localparam logic [31:0] A_STATUS  = 32'h14;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [7:0]  irq;
    logic        sel;

    logic [31:0] prdata8, prdata5, prdata;
    logic        pready8, pready5, pready;
    logic        irq_o8, irq_o5, irqo;
    logic        psel8, psel5;

    int n_checks;
    int n_fail;
    logic [31:0] rd_data;
    logic        rd_ready;

    assign psel8  = PSEL & ~sel;
    assign psel5  = PSEL & sel;
    assign prdata = sel ? prdata5 : prdata8;
    assign pready = sel ? pready5 : pready8;
    assign irqo   = sel ? irq_o5 : irq_o8;

    gpio_irq_ctrl #(.N_SRC(8)) dut8 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel8),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (prdata8),
        .PREADY  (pready8),
        .irq_i   (irq),
        .irq_o   (irq_o8)
    );

    gpio_irq_ctrl #(.N_SRC(5)) dut5 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel5),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (prdata5),
        .PREADY  (pready5),
        .irq_i   (irq[4:0]),
        .irq_o   (irq_o5)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [7:0] irq_acc);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        tick();
        PENABLE = 1'b1;
        irq = irq_acc;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        irq = 8'h00;
    endtask

    task automatic apb_read(input logic [31:0] addr);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        tick();
        PENABLE = 1'b1;
        #1;
        rd_data  = prdata;
        rd_ready = pready;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        irq      = 8'h00;
        PWDATA   = 32'h0;

        // Reset with an access phase held on the bus
        PRESETn = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = A_STATUS;
        tick();
        tick();
        check("rst_irq_o", {31'd0, irq_o8}, 32'h0);
        check("rst_pready", {31'd0, pready8}, 32'h0);
        check("rst_prdata", prdata8, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        tick();
        check("idle_pready", {31'd0, pready8}, 32'h0);
        apb_read(A_STATUS);
        check("rst_status", rd_data, 32'h0);
        check("read_pready", {31'd0, rd_ready}, 32'h1);

        // Setup phase only: no ready, no data
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_STATUS;
        #1;
        check("setup_pready", {31'd0, pready8}, 32'h0);
        check("setup_prdata", prdata8, 32'h0);
        PSEL = 1'b0;
        tick();

        // Single pulse on pin 3: latency, claim and complete
        apb_write(A_ENABLE, 32'hFF, 8'h00);
        apb_read(A_ENABLE);
        check("enable_rb", rd_data, 32'h000000FF);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        check("irq_o_t1", {31'd0, irq_o8}, 32'h0);
        tick();
        check("irq_o_t2", {31'd0, irq_o8}, 32'h1);
        apb_read(A_PENDING);
        check("pend_pin3", rd_data, 32'h08);
        apb_read(A_CLAIM);
        check("claim_3", rd_data, 32'h80000003);
        apb_read(A_PENDING);
        check("pend_after_claim", rd_data, 32'h0);
        check("irq_o_service", {31'd0, irq_o8}, 32'h0);
        apb_read(A_STATUS);
        check("status_service", rd_data, 32'h00030002);
        apb_write(A_CLAIM, 32'h3, 8'h00);
        apb_read(A_STATUS);
        check("status_after_cpl3", rd_data, 32'h00030400);

        // Round-robin over sources 0 and 7, wrong-ID complete
        do_reset();
        apb_write(A_ENABLE, 32'hFF, 8'h00);
        apb_write(A_SETPEND, 32'h81, 8'h00);
        tick();
        apb_read(A_CLAIM);
        check("claim_0", rd_data, 32'h80000000);
        apb_write(A_CLAIM, 32'h0, 8'h00);
        check("irq_o_cpl_t1", {31'd0, irq_o8}, 32'h0);
        tick();
        check("irq_o_cpl_t2", {31'd0, irq_o8}, 32'h1);
        apb_read(A_CLAIM);
        check("claim_7", rd_data, 32'h80000007);
        apb_write(A_CLAIM, 32'h5, 8'h00);
        apb_read(A_STATUS);
        check("status_wrong_id", rd_data, 32'h00070102);
        check("irq_o_wrong_id", {31'd0, irq_o8}, 32'h0);
        apb_write(A_CLAIM, 32'h7, 8'h00);
        apb_read(A_STATUS);
        check("status_ptr_wrap8", rd_data, 32'h00070000);

        // Overrun and set-over-clear priority on pin 2
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick();
        irq = 8'h04;
        tick();
        irq = 8'h00;
        apb_read(A_OVERRUN);
        check("overrun_set", rd_data, 32'h04);
        apb_write(A_OVERRUN, 32'h04, 8'h00);
        apb_read(A_OVERRUN);
        check("overrun_w1c", rd_data, 32'h0);
        apb_write(A_PENDING, 32'h04, 8'h04);
        apb_read(A_PENDING);
        check("pend_set_beats_w1c", rd_data, 32'h04);
        apb_read(A_OVERRUN);
        check("overrun_again", rd_data, 32'h04);
        apb_read(A_CLAIM);
        check("claim_2", rd_data, 32'h80000002);
        apb_write(A_CLAIM, 32'h2, 8'h00);
        apb_write(A_OVERRUN, 32'hFF, 8'h00);

        // Software trigger behind the mask, then unmask and re-mask
        apb_write(A_ENABLE, 32'h00, 8'h00);
        apb_write(A_SETPEND, 32'h10, 8'h00);
        apb_read(A_PENDING);
        check("pend_setpend", rd_data, 32'h10);
        check("irq_o_masked", {31'd0, irq_o8}, 32'h0);
        apb_write(A_ENABLE, 32'h10, 8'h00);
        check("irq_o_en_t1", {31'd0, irq_o8}, 32'h0);
        tick();
        check("irq_o_en_t2", {31'd0, irq_o8}, 32'h1);
        apb_write(A_ENABLE, 32'h00, 8'h00);
        tick();
        check("irq_o_unmasked_off", {31'd0, irq_o8}, 32'h0);
        apb_read(A_STATUS);
        check("status_mask_idle", rd_data, 32'h00020300);
        apb_write(A_PENDING, 32'h10, 8'h00);

        // Five-source instance: enable width, idle claim, pointer wrap
        do_reset();
        sel = 1'b1;
        apb_write(A_ENABLE, 32'hFF, 8'h00);
        apb_read(A_ENABLE);
        check("n5_enable_rb", rd_data, 32'h0000001F);
        apb_read(A_CLAIM);
        check("n5_claim_idle", rd_data, 32'h0);
        apb_read(A_STATUS);
        check("n5_status_idle", rd_data, 32'h0);
        apb_write(A_SETPEND, 32'h02, 8'h00);
        tick();
        apb_read(A_CLAIM);
        check("n5_claim_1", rd_data, 32'h80000001);
        apb_write(A_CLAIM, 32'h1, 8'h00);
        apb_read(A_STATUS);
        check("n5_status_ptr2", rd_data, 32'h00010200);
        apb_write(A_SETPEND, 32'h11, 8'h00);
        tick();
        apb_read(A_CLAIM);
        check("n5_claim_4", rd_data, 32'h80000004);
        apb_write(A_CLAIM, 32'h4, 8'h00);
        apb_read(A_STATUS);
        check("n5_status_wrap", rd_data, 32'h00040001);
        apb_read(A_CLAIM);
        check("n5_claim_0", rd_data, 32'h80000000);
        apb_write(A_CLAIM, 32'h0, 8'h00);
        apb_read(A_STATUS);
        check("n5_status_ptr1", rd_data, 32'h00000100);
        sel = 1'b0;

        // Reset in the middle of a service
        do_reset();
        apb_write(A_ENABLE, 32'hFF, 8'h00);
        apb_write(A_SETPEND, 32'h40, 8'h00);
        tick();
        apb_read(A_CLAIM);
        check("claim_6", rd_data, 32'h80000006);
        apb_read(A_STATUS);
        check("status_claim6", rd_data, 32'h00060002);
        apb_write(A_SETPEND, 32'h01, 8'h00);
        do_reset();
        check("irq_o_after_rst", {31'd0, irq_o8}, 32'h0);
        apb_read(A_STATUS);
        check("status_after_rst", rd_data, 32'h0);
        apb_read(A_PENDING);
        check("pend_after_rst", rd_data, 32'h0);
        apb_write(A_CLAIM, 32'h6, 8'h00);
        apb_read(A_STATUS);
        check("stale_complete", rd_data, 32'h0);
        apb_read(A_ENABLE);
        check("enable_after_rst", rd_data, 32'h0);
        apb_write(32'h18, 32'hFFFFFFFF, 8'h00);
        apb_read(32'h18);
        check("addr6_read", rd_data, 32'h0);
        apb_read(32'h1C);
        check("addr7_read", rd_data, 32'h0);
        apb_read(A_PENDING);
        check("addr6_write_ignored", rd_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
